// File: rtl/dem_bcd_mod.sv
// -----------------------------------------------------------------------------
// dem_bcd_mod
//
// Parametrised two-digit BCD modulo counter for one TM1638 clock time field
// (seconds/minutes with MOD=60, hours with MOD=24 or 12). The count runs
// 0..MOD-1 in either direction and can be preset. It also produces a one-cycle
// terminal-count pulse for cascading and a registered half-period square wave
// that drives the display blink/colon.
//
// The modulus parameter sets the count range and must lie in 2..99; the
// threshold parameter HALF defaults to half of it, and clk_out is 1 while
// the count is below that threshold.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rs       in   synchronous active-high reset
//   en       in   count enable, one step per enabled edge
//   up       in   direction: 1 = increment, 0 = decrement
//   ld       in   synchronous preset strobe (beats en, loses to rs)
//   ld_tens  in   preset tens digit (BCD)
//   ld_ones  in   preset ones digit (BCD)
//   led1     out  ones digit of the current count
//   led2     out  tens digit of the current count
//   tc       out  one-cycle pulse in the first cycle showing a wrapped value
//   clk_out  out  1 while count < HALF, else 0
//   ld_err   out  one-cycle pulse after a rejected preset
// -----------------------------------------------------------------------------
module dem_bcd_mod #(
    parameter int MOD  = 60,
    parameter int HALF = MOD / 2
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       en,
    input  logic       up,
    input  logic       ld,
    input  logic [3:0] ld_tens,
    input  logic [3:0] ld_ones,
    output logic [3:0] led1,
    output logic [3:0] led2,
    output logic       tc,
    output logic       clk_out,
    output logic       ld_err
);

    // Elaboration-time guard: outside 2..99 the count no longer fits in
    // two BCD digits, or the counter degenerates.
    if (MOD < 2 || MOD > 99) begin : g_bad_mod
        $error("dem_bcd_mod: MOD must be in 2..99");
    end

    // Terminal count MOD-1 split into BCD digits. Comparing both digits (not
    // just ones==9) is what lets MOD=24 wrap at 23.
    localparam logic [3:0] LAST_TENS = 4'((MOD - 1) / 10);
    localparam logic [3:0] LAST_ONES = 4'((MOD - 1) % 10);
    localparam logic [6:0] HALF_V    = 7'(HALF);
    localparam logic [7:0] MOD_V     = 8'(MOD);

    // Registered state
    logic [3:0] ones_q, tens_q;
    logic       tc_q, clk_out_q, ld_err_q;

    // Next-state values
    logic [3:0] ones_d, tens_d;
    logic       tc_d, ld_err_d;

    logic       at_last;     // count == MOD-1
    logic       at_zero;     // count == 0
    logic       ld_valid;    // preset digits are BCD and value < MOD
    logic [7:0] ld_value;    // binary value of the preset digits (up to 165)
    logic [6:0] next_value;  // binary value of the next count (up to 98)

    assign at_last = (tens_q == LAST_TENS) && (ones_q == LAST_ONES);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Preset value is formed from the raw 4-bit digits; a non-BCD digit is
    // rejected separately, so the product cannot alias into a legal value.
    assign ld_value = ({4'd0, ld_tens} * 8'd10) + {4'd0, ld_ones};
    assign ld_valid = (ld_tens <= 4'd9) && (ld_ones <= 4'd9) && (ld_value < MOD_V);

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: ld > en > hold; rs is applied in the
    // register process and beats all of them.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        ones_d   = ones_q;
        tens_d   = tens_q;
        tc_d     = 1'b0;
        ld_err_d = 1'b0;

        if (ld) begin
            if (ld_valid) begin
                ones_d = ld_ones;
                tens_d = ld_tens;
            end else begin
                // Rejected preset falls back to 00 rather than keeping a
                // possibly stale value, so time setting starts from a known point.
                ones_d   = 4'd0;
                tens_d   = 4'd0;
                ld_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_last) begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                    tc_d   = 1'b1;
                end else if (ones_q >= 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    ones_d = LAST_ONES;
                    tens_d = LAST_TENS;
                    tc_d   = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // clk_out is derived from the next count, not toggled, so it tracks
    // presets and down-counting without any history.
    assign next_value = ({3'd0, tens_d} * 7'd10) + {3'd0, ones_d};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rs) begin
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            tc_q      <= 1'b0;
            ld_err_q  <= 1'b0;
            clk_out_q <= 1'b1;
        end else begin
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            tc_q      <= tc_d;
            ld_err_q  <= ld_err_d;
            clk_out_q <= (next_value < HALF_V);
        end
    end

    // All outputs come straight from flops: no input-to-output path.
    assign led1    = ones_q;
    assign led2    = tens_q;
    assign tc      = tc_q;
    assign clk_out = clk_out_q;
    assign ld_err  = ld_err_q;

endmodule
